// File: rtl/traffic_monitor_if.sv
// Lamp inputs and monitor results for one intersection.
// The master side drives the lamps; the slave side is the monitor.
interface traffic_monitor_if;
    logic       Ga, Ya, Ra;
    logic       Gb, Yb, Rb;
    logic       Gw, Rw;
    logic [2:0] phase;
    logic       fault;
    logic [1:0] err_code;
    logic [7:0] cycles;

    modport master (
        output Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw,
        input  phase, fault, err_code, cycles
    );

    modport slave (
        input  Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw,
        output phase, fault, err_code, cycles
    );
endinterface

// File: rtl/traffic_monitor.sv
// Traffic light monitor: decodes the lamp pattern every sample, checks it for conflicts,
// illegal phase sequencing and over-long dwell, and counts completed signal cycles.
module traffic_monitor #(
    parameter int AG_MAX = 3,
    parameter int AY_MAX = 2,
    parameter int BG_MAX = 3,
    parameter int BY_MAX = 1,
    parameter int WG_MAX = 2
) (
    input  logic              clk_1hz,
    input  logic              rst,
    traffic_monitor_if.slave  mon
);

    typedef enum logic [2:0] {
        PH_UNKNOWN = 3'd0,
        PH_AG      = 3'd1,
        PH_AY      = 3'd2,
        PH_BG      = 3'd3,
        PH_BY      = 3'd4,
        PH_WG      = 3'd5,
        PH_ALLRED  = 3'd6,
        PH_INVALID = 3'd7
    } phase_t;

    phase_t     r_phase;
    logic [2:0] r_dwell;
    logic       r_fault;
    logic [1:0] r_errCode;
    logic [7:0] r_cycles;

    phase_t     w_cur;
    logic       w_anyGY;
    logic       w_multiA;
    logic       w_multiB;
    logic       w_conflict;
    logic       w_same;
    logic       w_checked;
    logic       w_legalNext;
    logic       w_illegal;
    logic       w_hasLimit;
    logic [2:0] w_limit;
    logic       w_overrun;
    logic [1:0] w_err;

    assign w_anyGY  = mon.Ga | mon.Ya | mon.Gb | mon.Yb;
    assign w_multiA = (mon.Ga & mon.Ya) | (mon.Ga & mon.Ra) | (mon.Ya & mon.Ra);
    assign w_multiB = (mon.Gb & mon.Yb) | (mon.Gb & mon.Rb) | (mon.Yb & mon.Rb);

    always_comb begin
        w_cur = PH_INVALID;
        if (mon.Ga & !mon.Ya & !mon.Ra & mon.Rb & !mon.Gb & !mon.Yb & !mon.Gw)
            w_cur = PH_AG;
        else if (mon.Ya & !mon.Ga & !mon.Ra & mon.Rb & !mon.Gb & !mon.Yb & !mon.Gw)
            w_cur = PH_AY;
        else if (mon.Gb & !mon.Yb & !mon.Rb & mon.Ra & !mon.Ga & !mon.Ya & !mon.Gw)
            w_cur = PH_BG;
        else if (mon.Yb & !mon.Gb & !mon.Rb & mon.Ra & !mon.Ga & !mon.Ya & !mon.Gw)
            w_cur = PH_BY;
        else if (mon.Gw & !mon.Rw & mon.Ra & mon.Rb & !w_anyGY)
            w_cur = PH_WG;
        else if (!w_anyGY & !mon.Gw & (mon.Ra == mon.Rb))
            w_cur = PH_ALLRED;
    end

    assign w_conflict = ((mon.Ga | mon.Ya) & (mon.Gb | mon.Yb)) | (mon.Gw & w_anyGY) |
                        (mon.Gw & mon.Rw) | w_multiA | w_multiB | (w_cur == PH_INVALID);

    // UNKNOWN and INVALID history both mean "no trusted previous phase", so skip the sequence check.
    assign w_same    = (w_cur == r_phase);
    assign w_checked = (r_phase != PH_UNKNOWN) && (r_phase != PH_INVALID);

    always_comb begin
        w_legalNext = 1'b0;
        case (r_phase)
            PH_AG:     w_legalNext = (w_cur == PH_AY);
            PH_AY:     w_legalNext = (w_cur == PH_BG);
            PH_BG:     w_legalNext = (w_cur == PH_BY);
            PH_BY:     w_legalNext = (w_cur == PH_WG);
            PH_WG:     w_legalNext = (w_cur == PH_ALLRED);
            PH_ALLRED: w_legalNext = (w_cur == PH_AG);
            default:   w_legalNext = 1'b0;
        endcase
    end

    assign w_illegal = w_checked && !w_same && (w_cur != PH_ALLRED) && !w_legalNext;

    always_comb begin
        w_hasLimit = 1'b1;
        w_limit    = 3'd7;
        case (w_cur)
            PH_AG:   w_limit = 3'(AG_MAX);
            PH_AY:   w_limit = 3'(AY_MAX);
            PH_BG:   w_limit = 3'(BG_MAX);
            PH_BY:   w_limit = 3'(BY_MAX);
            PH_WG:   w_limit = 3'(WG_MAX);
            default: w_hasLimit = 1'b0;
        endcase
    end

    assign w_overrun = w_same && w_hasLimit && (r_dwell == w_limit);

    assign w_err = w_conflict ? 2'd1 :
                   w_illegal  ? 2'd2 :
                   w_overrun  ? 2'd3 : 2'd0;

    // The first error wins and holds until reset; later errors are deliberately ignored.
    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            r_phase   <= PH_UNKNOWN;
            r_dwell   <= 3'd0;
            r_fault   <= 1'b0;
            r_errCode <= 2'd0;
            r_cycles  <= 8'd0;
        end else begin
            r_phase <= w_cur;
            if (!w_same)
                r_dwell <= 3'd1;
            else if (r_dwell != 3'd7)
                r_dwell <= r_dwell + 3'd1;
            if ((r_phase == PH_ALLRED) && (w_cur == PH_AG) && (r_cycles != 8'hFF))
                r_cycles <= r_cycles + 8'd1;
            if (!r_fault && (w_err != 2'd0)) begin
                r_fault   <= 1'b1;
                r_errCode <= w_err;
            end
        end
    end

    assign mon.phase    = r_phase;
    assign mon.fault    = r_fault;
    assign mon.err_code = r_errCode;
    assign mon.cycles   = r_cycles;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed testbench for traffic_monitor: each task drives one scenario and checks
// the registered outputs one time unit after the sampling edge.
module tb_traffic_monitor;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    traffic_monitor_if mon ();

    traffic_monitor dut (
        .clk_1hz (clock),
        .rst     (reset),
        .mon     (mon.slave)
    );

    // Lamp vectors are {Ga,Ya,Ra,Gb,Yb,Rb,Gw,Rw}
    localparam logic [7:0] L_AG   = 8'b100_001_01;
    localparam logic [7:0] L_AY   = 8'b010_001_01;
    localparam logic [7:0] L_BG   = 8'b001_100_01;
    localparam logic [7:0] L_BY   = 8'b001_010_01;
    localparam logic [7:0] L_WG   = 8'b001_001_10;
    localparam logic [7:0] L_AR   = 8'b001_001_01;
    localparam logic [7:0] L_DARK = 8'b000_000_00;
    localparam logic [7:0] L_GG   = 8'b100_100_00;

    localparam logic [7:0] CYCLE_LAMPS [13] = '{L_AG, L_AG, L_AG, L_AY, L_AY, L_BG, L_BG,
                                                 L_BG, L_BY, L_WG, L_WG, L_AR, L_AR};
    localparam logic [2:0] CYCLE_PHASE [13] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                                                 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic [7:0] lamps);
        {mon.Ga, mon.Ya, mon.Ra, mon.Gb, mon.Yb, mon.Rb, mon.Gw, mon.Rw} = lamps;
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(L_DARK);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus(L_AG);
        total++; if (mon.phase !== 3'd0) begin bad++; $display("[TB] FAIL reset_phase: got %0d expected 0", mon.phase); end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault: got %0d expected 0", mon.fault); end
        total++; if (mon.err_code !== 2'd0) begin bad++; $display("[TB] FAIL reset_err: got %0d expected 0", mon.err_code); end
        total++; if (mon.cycles !== 8'd0) begin bad++; $display("[TB] FAIL reset_cycles: got %0d expected 0", mon.cycles); end
        reset = 1'b0;
    endtask

    task automatic test_full_cycle();
        doReset();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(CYCLE_LAMPS[i]);
            total++; if (mon.phase !== CYCLE_PHASE[i]) begin bad++; $display("[TB] FAIL cycle_phase[%0d]: got %0d expected %0d", i, mon.phase, CYCLE_PHASE[i]); end
            total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL cycle_fault[%0d]: got %0d expected 0", i, mon.fault); end
        end
        total++; if (mon.cycles !== 8'd0) begin bad++; $display("[TB] FAIL cycle_count_before: got %0d expected 0", mon.cycles); end
        applyStimulus(L_AG);
        total++; if (mon.phase !== 3'd1) begin bad++; $display("[TB] FAIL cycle_wrap_phase: got %0d expected 1", mon.phase); end
        total++; if (mon.cycles !== 8'd1) begin bad++; $display("[TB] FAIL cycle_count_after: got %0d expected 1", mon.cycles); end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL cycle_wrap_fault: got %0d expected 0", mon.fault); end
    endtask

    task automatic test_conflict();
        doReset();
        applyStimulus(L_AG);
        applyStimulus(L_GG);
        total++; if (mon.phase !== 3'd7) begin bad++; $display("[TB] FAIL conflict_phase: got %0d expected 7", mon.phase); end
        total++; if (mon.fault !== 1'b1) begin bad++; $display("[TB] FAIL conflict_fault: got %0d expected 1", mon.fault); end
        total++; if (mon.err_code !== 2'd1) begin bad++; $display("[TB] FAIL conflict_err: got %0d expected 1", mon.err_code); end
        // AG four times after INVALID: the fourth is a dwell overrun, which must not replace the code
        for (int i = 0; i < 4; i++) applyStimulus(L_AG);
        total++; if (mon.phase !== 3'd1) begin bad++; $display("[TB] FAIL conflict_recover_phase: got %0d expected 1", mon.phase); end
        total++; if (mon.err_code !== 2'd1) begin bad++; $display("[TB] FAIL conflict_sticky_err: got %0d expected 1", mon.err_code); end
        total++; if (mon.fault !== 1'b1) begin bad++; $display("[TB] FAIL conflict_sticky_fault: got %0d expected 1", mon.fault); end
    endtask

    task automatic test_illegal();
        doReset();
        applyStimulus(L_AG);
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL illegal_pre_fault: got %0d expected 0", mon.fault); end
        applyStimulus(L_BG);
        total++; if (mon.phase !== 3'd3) begin bad++; $display("[TB] FAIL illegal_phase: got %0d expected 3", mon.phase); end
        total++; if (mon.fault !== 1'b1) begin bad++; $display("[TB] FAIL illegal_fault: got %0d expected 1", mon.fault); end
        total++; if (mon.err_code !== 2'd2) begin bad++; $display("[TB] FAIL illegal_err: got %0d expected 2", mon.err_code); end
    endtask

    task automatic test_dwell();
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(L_AG);
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL dwell_at_max_fault: got %0d expected 0", mon.fault); end
        applyStimulus(L_AG);
        total++; if (mon.fault !== 1'b1) begin bad++; $display("[TB] FAIL dwell_over_fault: got %0d expected 1", mon.fault); end
        total++; if (mon.err_code !== 2'd3) begin bad++; $display("[TB] FAIL dwell_over_err: got %0d expected 3", mon.err_code); end
        // BY allows only one sample
        doReset();
        applyStimulus(L_BY);
        applyStimulus(L_BY);
        total++; if (mon.err_code !== 2'd3) begin bad++; $display("[TB] FAIL dwell_by_err: got %0d expected 3", mon.err_code); end
    endtask

    task automatic test_flash();
        doReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? L_AR : L_DARK);
            total++; if (mon.phase !== 3'd6) begin bad++; $display("[TB] FAIL flash_phase[%0d]: got %0d expected 6", i, mon.phase); end
        end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL flash_fault: got %0d expected 0", mon.fault); end
        applyStimulus(L_AG);
        total++; if (mon.phase !== 3'd1) begin bad++; $display("[TB] FAIL flash_exit_phase: got %0d expected 1", mon.phase); end
        total++; if (mon.cycles !== 8'd1) begin bad++; $display("[TB] FAIL flash_cycles: got %0d expected 1", mon.cycles); end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL flash_exit_fault: got %0d expected 0", mon.fault); end
    endtask

    task automatic test_reset_mid();
        doReset();
        applyStimulus(L_AG);
        applyStimulus(L_BG);
        total++; if (mon.err_code !== 2'd2) begin bad++; $display("[TB] FAIL mid_pre_err: got %0d expected 2", mon.err_code); end
        reset = 1'b1;
        applyStimulus(L_BG);
        total++; if (mon.phase !== 3'd0) begin bad++; $display("[TB] FAIL mid_rst_phase: got %0d expected 0", mon.phase); end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_fault: got %0d expected 0", mon.fault); end
        reset = 1'b0;
        applyStimulus(L_BG);
        total++; if (mon.phase !== 3'd3) begin bad++; $display("[TB] FAIL mid_after_phase: got %0d expected 3", mon.phase); end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL mid_after_fault: got %0d expected 0", mon.fault); end
        total++; if (mon.err_code !== 2'd0) begin bad++; $display("[TB] FAIL mid_after_err: got %0d expected 0", mon.err_code); end
    endtask

    task automatic test_saturation();
        doReset();
        for (int k = 1; k <= 256; k++) begin
            for (int i = 0; i < 13; i++) applyStimulus(CYCLE_LAMPS[i]);
            if (k == 200) begin
                total++; if (mon.cycles !== 8'd199) begin bad++; $display("[TB] FAIL sat_mid_cycles: got %0d expected 199", mon.cycles); end
            end
        end
        total++; if (mon.cycles !== 8'd255) begin bad++; $display("[TB] FAIL sat_at_255: got %0d expected 255", mon.cycles); end
        applyStimulus(L_AG);
        total++; if (mon.cycles !== 8'd255) begin bad++; $display("[TB] FAIL sat_hold: got %0d expected 255", mon.cycles); end
        total++; if (mon.fault !== 1'b0) begin bad++; $display("[TB] FAIL sat_fault: got %0d expected 0", mon.fault); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        {mon.Ga, mon.Ya, mon.Ra, mon.Gb, mon.Yb, mon.Rb, mon.Gw, mon.Rw} = L_DARK;
        @(negedge clock);
        test_reset();
        test_full_cycle();
        test_conflict();
        test_illegal();
        test_dwell();
        test_flash();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_monitor.md
TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

Interface
REQ-001 Parameter: AG_MAX, 3, maximum consecutive samples in phase AG.
REQ-002 Parameter: AY_MAX, 2, maximum consecutive samples in phase AY.
REQ-003 Parameter: BG_MAX, 3, maximum consecutive samples in phase BG.
REQ-004 Parameter: BY_MAX, 1, maximum consecutive samples in phase BY.
REQ-005 Parameter: WG_MAX, 2, maximum consecutive samples in phase WG.
REQ-006 One clock; reset is synchronous and active-high; all logic SHALL be clocked on the rising edge of clk_1hz.
REQ-007 clk_1hz  input  1  sample clock; one sample per edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 Ga, Ya, Ra  input  1 each  approach A green, yellow and red lamps.
REQ-010 Gb, Yb, Rb  input  1 each  approach B green, yellow and red lamps.
REQ-011 Gw, Rw  input  1 each  walk and don't-walk lamps.
REQ-012 phase  output  3  decoded phase: 0 UNKNOWN, 1 AG, 2 AY, 3 BG, 4 BY, 5 WG, 6 ALLRED, 7 INVALID.
REQ-013 fault  output  1  sticky; set on the first detected error.
REQ-014 err_code  output  2  first error: 0 none, 1 conflict, 2 illegal transition, 3 dwell overrun.
REQ-015 cycles  output  8  completed signal cycles, saturating.

Function
REQ-016 Decode, one sample per edge:
- AG = Ga & !Ya & !Ra & Rb & !Gb & !Yb & !Gw.
- AY = Ya & !Ga & !Ra & Rb & !Gb & !Yb & !Gw.
- BG = Gb & !Yb & !Rb & Ra & !Ga & !Ya & !Gw.
- BY = Yb & !Gb & !Rb & Ra & !Ga & !Ya & !Gw.
- WG = Gw & !Rw & Ra & Rb, with no green or yellow lamp lit.
- ALLRED = no green or yellow lamp lit, Gw=0, Ra==Rb; Rw is don't-care because flash phases blink it.
- Any other combination decodes to INVALID.
REQ-017 Conflict SHALL be flagged on any sample with any of:
- (Ga|Ya)&(Gb|Yb);
- Gw&(Ga|Ya|Gb|Yb);
- Gw&Rw;
- more than one lamp lit among {Ga,Ya,Ra} or among {Gb,Yb,Rb}.
- Any other INVALID sample SHALL also count as a conflict.
REQ-018 Legal transitions from the previous phase:
- AG->AY, AY->BG, BG->BY, BY->WG, WG->ALLRED, ALLRED->AG.
- Any phase->ALLRED.
- Any phase to itself.
- UNKNOWN to any non-INVALID phase, with no check.
- Any other transition is an illegal transition.
REQ-019 Dwell counter (3 bits):
- Loads 1 on phase change.
- Increments, saturating at 7, on the same phase.
- A same-phase sample with dwell already equal to that phase's *_MAX SHALL flag dwell overrun.
- ALLRED and UNKNOWN have no limit.
REQ-020 Error priority within one sample: conflict > illegal transition > dwell overrun.
REQ-021 err_code SHALL capture only the first error after reset, holding until rst even if later errors occur.
REQ-022 cycles SHALL increment on each ALLRED->AG transition and saturate at 255.
REQ-023 Outputs SHALL be registered: phase, fault, err_code and cycles reflect the lamps sampled at the same edge (one-edge latency from lamp change).
REQ-024 After an INVALID sample, the previous phase SHALL become INVALID. The next valid phase SHALL be accepted without a transition check, as from UNKNOWN.

Reset
REQ-025 When rst=1 at an edge:
- phase=0, fault=0, err_code=0, cycles=0, dwell=0, previous phase=UNKNOWN.
- Lamp inputs on that edge are ignored.
REQ-026 Reset asserted mid-cycle or mid-error SHALL clear all state at the same edge. The first sample after rst deasserts is treated as from UNKNOWN.

Verification
REQ-027 Legal full cycle: AG x3, AY x2, BG x3, BY x1, WG x2, ALLRED x2, then AG -> fault stays 0, phase tracks 1..6, cycles=1 on the AG edge.
REQ-028 Conflict: Ga=1 and Gb=1 on one sample -> phase=7, fault=1, err_code=1 at that edge; a later dwell error leaves err_code=1.
REQ-029 Illegal transition: AG then BG -> fault=1, err_code=2.
REQ-030 Dwell overrun: AG held for 4 samples -> fault=1, err_code=3 at the 4th edge.
REQ-031 Flash: Ra=Rb=Rw toggling with all green and yellow lamps 0 for 10 samples, then AG -> phase=6 throughout, no fault, cycles increments by 1.
REQ-032 Reset mid-cycle after a fault, plus saturation:
- rst for one edge, then BG sample -> phase=3, fault=0, err_code=0.
- 256 legal cycles -> cycles=255.
